// File: rtl/cu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cu_pkg
//  Description : Shared types and constants for the multicycle control unit:
//                FSM state enum, ALU operation codes, condition codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package cu_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXECR  = 4'd6,
        ST_EXECI  = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9
    } cu_state_e;

    localparam logic [2:0] c_alu_add = 3'd0;
    localparam logic [2:0] c_alu_sub = 3'd1;
    localparam logic [2:0] c_alu_and = 3'd2;
    localparam logic [2:0] c_alu_orr = 3'd3;
    localparam logic [2:0] c_alu_mul = 3'd4;

    localparam logic [3:0] c_cond_eq = 4'h0;
    localparam logic [3:0] c_cond_ne = 4'h1;
    localparam logic [3:0] c_cond_cs = 4'h2;
    localparam logic [3:0] c_cond_cc = 4'h3;
    localparam logic [3:0] c_cond_mi = 4'h4;
    localparam logic [3:0] c_cond_pl = 4'h5;
    localparam logic [3:0] c_cond_vs = 4'h6;
    localparam logic [3:0] c_cond_vc = 4'h7;
    localparam logic [3:0] c_cond_hi = 4'h8;
    localparam logic [3:0] c_cond_ls = 4'h9;
    localparam logic [3:0] c_cond_ge = 4'hA;
    localparam logic [3:0] c_cond_lt = 4'hB;
    localparam logic [3:0] c_cond_gt = 4'hC;
    localparam logic [3:0] c_cond_le = 4'hD;
    localparam logic [3:0] c_cond_al = 4'hE;
    localparam logic [3:0] c_cond_nv = 4'hF;

endpackage
`default_nettype wire

// File: rtl/cond_check.sv
`default_nettype none
// ============================================================================
//  Module      : cond_check
//  Description : Evaluates a 4-bit condition code against the N,Z,C,V flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_check
    import cu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic w_n, w_z, w_c, w_v;
    assign {w_n, w_z, w_c, w_v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            c_cond_eq: cond_ex = w_z;
            c_cond_ne: cond_ex = ~w_z;
            c_cond_cs: cond_ex = w_c;
            c_cond_cc: cond_ex = ~w_c;
            c_cond_mi: cond_ex = w_n;
            c_cond_pl: cond_ex = ~w_n;
            c_cond_vs: cond_ex = w_v;
            c_cond_vc: cond_ex = ~w_v;
            c_cond_hi: cond_ex = w_c & ~w_z;
            c_cond_ls: cond_ex = ~w_c | w_z;
            c_cond_ge: cond_ex = (w_n == w_v);
            c_cond_lt: cond_ex = (w_n != w_v);
            c_cond_gt: cond_ex = ~w_z & (w_n == w_v);
            c_cond_le: cond_ex = w_z | (w_n != w_v);
            c_cond_al: cond_ex = 1'b1;
            c_cond_nv: cond_ex = 1'b0;
            default:   cond_ex = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_unit
//  Description : Multicycle CPU control FSM with conditional execution and a
//                status-flag register. Define CU_MUL_EN to decode MUL.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int ALU_W  = 4,
    parameter int FLAG_W = 4
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        cond,
    input  logic [1:0]        op,
    input  logic [5:0]        funct,
    input  logic [3:0]        rd,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic              pc_write,
    output logic              ir_write,
    output logic              reg_write,
    output logic              mem_write,
    output logic              adr_src,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        result_src,
    output logic [1:0]        imm_src,
    output logic [1:0]        reg_src,
    output logic [ALU_W-1:0]  alu_control
);

    cu_state_e  r_state, w_next;
    logic [3:0] r_cond;
    logic [4:0] r_funct;
    logic [3:0] r_rd;
    logic [3:0] r_flags;

    logic       w_cond_ex;
    logic [2:0] w_dp_op, w_alu_op;
    logic       w_dp_cv, w_is_cmp, w_is_exec, w_flag_upd;
    logic [3:0] w_flags_next;
    logic       w_pc_write, w_ir_write, w_reg_write, w_mem_write;

    cond_check u_cond_check (
        .cond    (r_cond),
        .flags   (r_flags),
        .cond_ex (w_cond_ex)
    );

    // Data-processing decode; w_dp_cv marks ops whose C,V results are kept.
    always_comb begin
        w_dp_op = c_alu_add;
        w_dp_cv = 1'b1;
        case (r_funct[4:1])
            4'b0100: begin w_dp_op = c_alu_add; w_dp_cv = 1'b1; end
            4'b0010: begin w_dp_op = c_alu_sub; w_dp_cv = 1'b1; end
            4'b0000: begin w_dp_op = c_alu_and; w_dp_cv = 1'b0; end
            4'b1100: begin w_dp_op = c_alu_orr; w_dp_cv = 1'b0; end
            4'b1010: begin w_dp_op = c_alu_sub; w_dp_cv = 1'b1; end
`ifdef CU_MUL_EN
            4'b0001: begin w_dp_op = c_alu_mul; w_dp_cv = 1'b0; end
`else
            4'b0001: begin w_dp_op = c_alu_add; w_dp_cv = 1'b1; end
`endif
            default: begin w_dp_op = c_alu_add; w_dp_cv = 1'b1; end
        endcase
    end

    assign w_is_cmp   = (r_funct[4:1] == 4'b1010);
    assign w_is_exec  = (r_state == ST_EXECR) || (r_state == ST_EXECI);
    // CMP ignores the S bit and its condition; other ops need S and a pass.
    assign w_flag_upd = w_is_exec & (w_is_cmp | (r_funct[0] & w_cond_ex));
    assign w_flags_next = {alu_flags[3:2], (w_dp_cv ? alu_flags[1:0] : r_flags[1:0])};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_FETCH;
            r_cond  <= 4'd0;
            r_funct <= 5'd0;
            r_rd    <= 4'd0;
            r_flags <= 4'd0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_cond  <= cond;
                r_funct <= funct[4:0];
                r_rd    <= rd;
            end
            if (w_flag_upd) begin
                r_flags <= w_flags_next;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'd0;
        result_src  = 2'd0;
        reg_src     = 2'd0;
        w_alu_op    = c_alu_add;
        case (r_state)
            ST_FETCH: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                result_src = 2'd2;
                w_next     = ST_DECODE;
            end
            ST_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                result_src = 2'd2;
                case (op)
                    2'b01:   w_next = ST_MEMADR;
                    2'b00:   w_next = funct[5] ? ST_EXECI : ST_EXECR;
                    2'b10:   w_next = ST_BRANCH;
                    default: w_next = ST_FETCH;
                endcase
            end
            ST_MEMADR: begin
                alu_src_b = 2'd1;
                w_next    = r_funct[0] ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                adr_src = 1'b1;
                w_next  = ST_MEMWB;
            end
            ST_MEMWB: begin
                result_src  = 2'd1;
                w_reg_write = w_cond_ex;
                w_pc_write  = w_cond_ex & (r_rd == 4'd15);
                w_next      = ST_FETCH;
            end
            ST_MEMWR: begin
                adr_src     = 1'b1;
                w_mem_write = w_cond_ex;
                w_next      = ST_FETCH;
            end
            ST_EXECR: begin
                w_alu_op = w_dp_op;
                w_next   = ST_ALUWB;
            end
            ST_EXECI: begin
                alu_src_b = 2'd1;
                w_alu_op  = w_dp_op;
                w_next    = ST_ALUWB;
            end
            ST_ALUWB: begin
                w_reg_write = w_cond_ex & ~w_is_cmp;
                w_pc_write  = w_cond_ex & ~w_is_cmp & (r_rd == 4'd15);
                w_next      = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_b  = 2'd1;
                result_src = 2'd2;
                w_pc_write = w_cond_ex;
                w_next     = ST_FETCH;
            end
            default: w_next = ST_FETCH;
        endcase
    end

    // Write strobes are held off for as long as reset is asserted.
    assign pc_write    = w_pc_write  & rst;
    assign ir_write    = w_ir_write  & rst;
    assign reg_write   = w_reg_write & rst;
    assign mem_write   = w_mem_write & rst;
    assign imm_src     = op;
    assign alu_control = ALU_W'(w_alu_op);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control_unit
//  Description : Self-checking bench: per-instruction behavioural model with
//                randomized stimulus. Honours CU_MUL_EN like the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

    localparam int VW   = 18;
    localparam int P_PC = 17;
    localparam int P_RW = 15;
    localparam int P_MW = 14;

    logic       clk, rst;
    logic [3:0] cond, rd, alu_flags;
    logic [1:0] op;
    logic [5:0] funct;
    logic       pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a;
    logic [1:0] alu_src_b, result_src, imm_src, reg_src;
    logic [3:0] alu_control;

    multicycle_control_unit #(.ALU_W(4), .FLAG_W(4)) dut (
        .clk(clk), .rst(rst), .cond(cond), .op(op), .funct(funct), .rd(rd),
        .alu_flags(alu_flags), .pc_write(pc_write), .ir_write(ir_write),
        .reg_write(reg_write), .mem_write(mem_write), .adr_src(adr_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .imm_src(imm_src), .reg_src(reg_src), .alu_control(alu_control)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [VW-1:0]   exp_vec;
    logic [VW-1:0]   cmp_act;
    bit              exp_valid = 0;
    string           exp_name;
    logic [1:0]      cur_op;
    logic [3:0]      mflags;
    bit              af_ovr_en;
    logic [3:0]      af_ovr;
    logic [VW-1:0]   hist[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Flags are {N,Z,C,V}.
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic dp_decode(input logic [3:0] f4, output logic [2:0] alu,
                             output bit cv, output bit cmp);
        cmp = (f4 == 4'b1010);
        alu = 3'd0; cv = 1'b1;
        if (f4 == 4'b0010 || f4 == 4'b1010) alu = 3'd1;
        else if (f4 == 4'b0000) begin alu = 3'd2; cv = 1'b0; end
        else if (f4 == 4'b1100) begin alu = 3'd3; cv = 1'b0; end
`ifdef CU_MUL_EN
        else if (f4 == 4'b0001) begin alu = 3'd4; cv = 1'b0; end
`endif
    endtask

    function automatic logic [VW-1:0] mk(input bit pc, input bit ir, input bit rw,
        input bit mw, input bit adr, input bit a, input logic [1:0] b,
        input logic [1:0] r, input logic [2:0] alu);
        return {pc, ir, rw, mw, adr, a, b, r, cur_op, 2'b00, {1'b0, alu}};
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            cmp_act = {pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a,
                       alu_src_b, result_src, imm_src, reg_src, alu_control};
            hist.push_back(cmp_act);
            chk(exp_name, 32'(cmp_act), 32'(exp_vec));
        end
    end

    task automatic cyc(input string nm, input logic [VW-1:0] e, output logic [3:0] af);
        af = af_ovr_en ? af_ovr : 4'($urandom);
        alu_flags = af;
        exp_vec   = e;
        exp_name  = nm;
        exp_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_instr(input logic [3:0] c, input logic [1:0] o,
                             input logic [5:0] f, input logic [3:0] r);
        logic [3:0] af;
        logic [2:0] alu;
        bit cv, cmp, cex, w, r15;
        cond = c; op = o; funct = f; rd = r; cur_op = o;
        hist.delete();
        r15 = (r == 4'd15);
        cex = cond_ok(c, mflags);
        cyc("FETCH",  mk(1, 1, 0, 0, 0, 1, 2'd2, 2'd2, 3'd0), af);
        cyc("DECODE", mk(0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 3'd0), af);
        case (o)
            2'b01: begin
                cyc("MEMADR", mk(0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 3'd0), af);
                if (f[0]) begin
                    cyc("MEMRD", mk(0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 3'd0), af);
                    cyc("MEMWB", mk(cex && r15, 0, cex, 0, 0, 0, 2'd0, 2'd1, 3'd0), af);
                end else begin
                    cyc("MEMWR", mk(0, 0, 0, cex, 1, 0, 2'd0, 2'd0, 3'd0), af);
                end
            end
            2'b00: begin
                dp_decode(f[4:1], alu, cv, cmp);
                cyc("EXEC", mk(0, 0, 0, 0, 0, 0, {1'b0, f[5]}, 2'd0, alu), af);
                if (cmp || (f[0] && cex)) begin
                    mflags[3:2] = af[3:2];
                    if (cv) mflags[1:0] = af[1:0];
                end
                // The writeback condition sees the flags as just updated.
                w = cond_ok(c, mflags) && !cmp;
                cyc("ALUWB", mk(w && r15, 0, w, 0, 0, 0, 2'd0, 2'd0, 3'd0), af);
            end
            2'b10: cyc("BRANCH", mk(cex, 0, 0, 0, 0, 0, 2'd1, 2'd2, 3'd0), af);
            default: ;
        endcase
    endtask

    task automatic reset_in_memwr();
        logic [3:0] af;
        cond = 4'hE; op = 2'b01; funct = 6'b000000; rd = 4'd3; cur_op = 2'b01;
        hist.delete();
        cyc("FETCH",  mk(1, 1, 0, 0, 0, 1, 2'd2, 2'd2, 3'd0), af);
        cyc("DECODE", mk(0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 3'd0), af);
        cyc("MEMADR", mk(0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 3'd0), af);
        exp_valid = 1'b0;
        chk("memwr_before_rst", 32'(mem_write), 32'd1);
        exp_vec  = mk(0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 3'd0);
        exp_name = "RESET_MID";
        #2 rst = 1'b0;
        #1 chk("rst_mem_write_now", 32'(mem_write), 32'd0);
        exp_valid = 1'b1;
        mflags = 4'd0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; cond = 4'd0; op = 2'd0; funct = 6'd0; rd = 4'd0;
        alu_flags = 4'd0; cur_op = 2'd0; mflags = 4'd0; af_ovr_en = 0; af_ovr = 4'd0;
        exp_name  = "RESET";
        exp_vec   = mk(0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 3'd0);
        exp_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        chk("model_eq_z",  32'(cond_ok(4'h0, 4'b0100)), 32'd1);
        chk("model_gt_nv", 32'(cond_ok(4'hC, 4'b1001)), 32'd1);
        chk("model_never", 32'(cond_ok(4'hF, 4'b1111)), 32'd0);

        // ADD r2, AL, no S
        run_instr(4'hE, 2'b00, 6'b001000, 4'd2);
        chk("add_exec_rw", 32'(hist[2][P_RW]), 32'd0);
        chk("add_wb_rw",   32'(hist[3][P_RW]), 32'd1);
        chk("add_alu",     32'(hist[2][3:0]),  32'd0);

        // CMP equal then BEQ taken
        af_ovr_en = 1; af_ovr = 4'b0100;
        run_instr(4'hE, 2'b00, 6'b010101, 4'd0);
        chk("cmp_eq_flags", 32'(mflags), 32'h4);
        run_instr(4'h0, 2'b10, 6'b000000, 4'd0);
        chk("beq_taken_pc", 32'(hist[2][P_PC]), 32'd1);

        // CMP differing then BEQ not taken
        af_ovr = 4'b0000;
        run_instr(4'hE, 2'b00, 6'b010101, 4'd0);
        run_instr(4'h0, 2'b10, 6'b000000, 4'd0);
        chk("beq_not_taken_pc", 32'(hist[2][P_PC]), 32'd0);

        // LDR to r15
        run_instr(4'hE, 2'b01, 6'b000001, 4'd15);
        chk("ldr_pc_rw", 32'({hist[4][P_PC], hist[4][P_RW]}), 32'd3);

        // STRNE with Z set
        af_ovr = 4'b0100;
        run_instr(4'hE, 2'b00, 6'b010101, 4'd0);
        run_instr(4'h1, 2'b01, 6'b000000, 4'd4);
        chk("strne_mem_write", 32'(hist[3][P_MW]), 32'd0);

        // funct 0001 decode
        run_instr(4'hE, 2'b00, 6'b000010, 4'd5);
`ifdef CU_MUL_EN
        chk("mul_alu", 32'(hist[2][3:0]), 32'd4);
`else
        chk("mul_alu", 32'(hist[2][3:0]), 32'd0);
`endif

        // Reset during MEMWR with Z set beforehand; BEQ after must not branch
        run_instr(4'hE, 2'b00, 6'b010101, 4'd0);
        af_ovr_en = 0;
        reset_in_memwr();
        run_instr(4'h0, 2'b10, 6'b000000, 4'd0);
        chk("post_rst_beq_pc", 32'(hist[2][P_PC]), 32'd0);

        for (int i = 0; i < 400; i++) begin
            logic [3:0] c, r;
            c = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            run_instr(c, 2'($urandom_range(0, 3)), 6'($urandom), r);
        end

        exp_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter ALU_W, default 4, SHALL set alu_control width; op codes zero-extended to it; ALU_W < 3 is illegal.
REQ-002 Parameter FLAG_W, default 4, SHALL set alu_flags width; bits [3:0] are N,Z,C,V; bits above 3 are ignored.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 cond  in  4; op  in  2; funct  in  6; rd  in  4: instruction fields, sampled only in DECODE.
REQ-006 alu_flags  in  FLAG_W  ALU status of the current cycle.
REQ-007 pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a  out  1 each  datapath strobes/selects.
REQ-008 alu_src_b, result_src, imm_src, reg_src  out  2 each  datapath selects.
REQ-009 alu_control  out  ALU_W  ALU operation.

Function
REQ-010 FSM states SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
REQ-011 FETCH: ir_write=1, pc_write=1, adr_src=0, alu_src_a=1, alu_src_b=2, alu_control=ADD, result_src=2; next DECODE.
REQ-012 DECODE: alu_src_a=1, alu_src_b=2, alu_control=ADD, result_src=2; capture cond/op/funct/rd into internal registers; next by op: 01->MEMADR, 00 with funct[5]=1->EXECI, 00 with funct[5]=0->EXECR, 10->BRANCH, 11->FETCH (undefined, no side effects).
REQ-013 MEMADR: alu_src_a=0, alu_src_b=1, alu_control=ADD; next MEMRD if funct[0]=1 (LDR), else MEMWR (STR).
REQ-014 MEMRD: adr_src=1, result_src=0; next MEMWB.
REQ-015 MEMWB: result_src=1, reg_write=cond_ex; next FETCH.
REQ-016 MEMWR: adr_src=1, mem_write=cond_ex; next FETCH.
REQ-017 EXECR/EXECI: alu_src_a=0, alu_src_b=0 (EXECR) or 1 (EXECI); alu_control from funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB); others ADD; next ALUWB.
REQ-018 ALUWB: result_src=0, reg_write=cond_ex unless CMP; next FETCH.
REQ-019 BRANCH: alu_src_a=0, alu_src_b=1, alu_control=ADD, result_src=2, pc_write=cond_ex; next FETCH.
REQ-020 Any MEMWB/ALUWB write with rd=15 SHALL also assert pc_write=cond_ex.
REQ-021 cond_ex SHALL be evaluated combinationally from the latched cond and the internal flags register: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 0.
REQ-022 Flags register SHALL update on the clock edge leaving EXECR/EXECI when funct[0]=1 (S) and cond_ex=1; N,Z always; C,V only for ADD/SUB/CMP. CMP always updates flags.
REQ-023 Outputs not listed for a state SHALL be 0; imm_src = op in every state.
REQ-024 Instruction latency: LDR 5 cycles, STR 4, data-processing 4, branch 3, undefined 2.

Reset
REQ-025 rst low SHALL immediately force state FETCH, flags 0, latched fields 0; all strobes read as FETCH-state values only after rst deasserts; while rst low, pc_write, ir_write, reg_write and mem_write SHALL be 0.
REQ-026 Reset mid-instruction SHALL abandon it with no register, memory or flag write.

Configuration
REQ-027 With CU_MUL_EN defined, funct[4:1]=0001 (data-processing) SHALL select alu_control=MUL (4) and update only N,Z; without it, 0001 decodes as ADD.

Structure
REQ-028 Package cu_pkg SHALL hold the state enum, ALU op constants (ADD 0, SUB 1, AND 2, ORR 3, MUL 4) and the 16 condition-code constants.
REQ-029 Condition evaluation SHALL be a sub-module cond_check (cond, flags -> cond_ex).

Verification
REQ-030 ADD with rd=2, cond=AL, S=0 after reset -> states FETCH,DECODE,EXECR,ALUWB; reg_write=1 in cycle 4 only; alu_control=0.
REQ-031 CMP with equal operands (flags Z=1) then BEQ -> flags=0100; BRANCH asserts pc_write; with operands differing, pc_write=0 in BRANCH.
REQ-032 LDR to rd=15, cond=AL -> 5 cycles; MEMWB asserts reg_write=1 and pc_write=1.
REQ-033 STR with cond=NE while Z=1 -> mem_write stays 0 through MEMWR; next state FETCH.
REQ-034 rst pulled low during MEMWR -> mem_write=0 immediately; after release, state FETCH with flags 0.
REQ-035 funct[4:1]=0001 -> alu_control=4 with CU_MUL_EN, 0 without.
